// File: rtl/skeleton_bus_arbiter.sv
// rtl/skeleton_bus_arbiter.sv - round-robin N-master / M-slave register bus interconnect
module skeleton_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {16'd35840, 16'd8192},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_SIZE = {16'd1024, 16'd256},
  parameter int TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [NUM_MASTERS-1:0]        m_err,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [NUM_SLAVES-1:0]         s_sel,
  output logic                          s_we,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic [NUM_SLAVES-1:0]         s_ack,
  input  logic [NUM_SLAVES*DATA_W-1:0]  s_rdata
);

  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [ADDR_W:0] ADDR_LIMIT = {1'b1, {ADDR_W{1'b0}}};

  // Parameter sanity: reject empty windows and windows running past the address space
  if (NUM_MASTERS < 1 || NUM_MASTERS > 8) begin : g_bad_nm
    $error("skeleton_bus_arbiter: NUM_MASTERS out of range 1..8");
  end
  if (NUM_SLAVES < 1 || NUM_SLAVES > 8) begin : g_bad_ns
    $error("skeleton_bus_arbiter: NUM_SLAVES out of range 1..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_to
    $error("skeleton_bus_arbiter: TIMEOUT out of range 1..65535");
  end
  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_map_check
    localparam logic [ADDR_W:0] BASE_K = {1'b0, SLAVE_BASE[k*ADDR_W +: ADDR_W]};
    localparam logic [ADDR_W:0] SIZE_K = {1'b0, SLAVE_SIZE[k*ADDR_W +: ADDR_W]};
    if (SIZE_K == '0) begin : g_zero_size
      $error("skeleton_bus_arbiter: slave window size must be non-zero");
    end
    if (BASE_K + SIZE_K > ADDR_LIMIT) begin : g_overflow
      $error("skeleton_bus_arbiter: slave window exceeds address space");
    end
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                  state_q,   state_d;
  logic [MW-1:0]           rr_q,      rr_d;
  logic [MW-1:0]           win_q,     win_d;
  logic [SW-1:0]           slv_q,     slv_d;
  logic [15:0]             cnt_q,     cnt_d;
  logic [NUM_MASTERS-1:0]  m_ack_q,   m_ack_d;
  logic [NUM_MASTERS-1:0]  m_err_q,   m_err_d;
  logic [DATA_W-1:0]       m_rdata_q, m_rdata_d;
  logic [NUM_SLAVES-1:0]   s_sel_q,   s_sel_d;
  logic                    s_we_q,    s_we_d;
  logic [ADDR_W-1:0]       s_addr_q,  s_addr_d;
  logic [DATA_W-1:0]       s_wdata_q, s_wdata_d;

  logic                    arb_found;
  logic [MW-1:0]           arb_idx;
  logic [MW-1:0]           cand;
  logic [ADDR_W-1:0]       sel_addr;
  logic                    sel_we;
  logic [DATA_W-1:0]       sel_wdata;
  logic                    dec_hit;
  logic [SW-1:0]           dec_idx;
  logic [ADDR_W-1:0]       dec_local;
  logic                    slv_ack;
  logic [DATA_W-1:0]       slv_rdata;

  // Round-robin pick: first requester strictly after the last winner, wrapping
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = rr_q;
    cand      = rr_q;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = MW'((int'(rr_q) + i) % NUM_MASTERS);
      if (!arb_found && m_req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign sel_addr  = m_addr[arb_idx*ADDR_W +: ADDR_W];
  assign sel_we    = m_we[arb_idx];
  assign sel_wdata = m_wdata[arb_idx*DATA_W +: DATA_W];

  // Address decode with one spare bit so base+size never wraps; scanning down lets the lowest slave win
  always_comb begin
    dec_hit   = 1'b0;
    dec_idx   = '0;
    dec_local = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if (({1'b0, sel_addr} >= {1'b0, SLAVE_BASE[k*ADDR_W +: ADDR_W]}) &&
          ({1'b0, sel_addr} <  ({1'b0, SLAVE_BASE[k*ADDR_W +: ADDR_W]} +
                                {1'b0, SLAVE_SIZE[k*ADDR_W +: ADDR_W]}))) begin
        dec_hit   = 1'b1;
        dec_idx   = SW'(k);
        dec_local = sel_addr - SLAVE_BASE[k*ADDR_W +: ADDR_W];
      end
    end
  end

  // Only the slave currently being accessed may complete the transfer
  assign slv_ack   = s_ack[slv_q];
  assign slv_rdata = s_rdata[slv_q*DATA_W +: DATA_W];

  // Next-state and registered-output computation for the transfer FSM
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    win_d     = win_q;
    slv_d     = slv_q;
    cnt_d     = cnt_q;
    m_ack_d   = '0;
    m_err_d   = '0;
    m_rdata_d = '0;
    s_sel_d   = s_sel_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          rr_d  = arb_idx;
          win_d = arb_idx;
          if (dec_hit) begin
            state_d          = ST_ACCESS;
            slv_d            = dec_idx;
            cnt_d            = '0;
            s_sel_d          = '0;
            s_sel_d[dec_idx] = 1'b1;
            s_we_d           = sel_we;
            s_addr_d         = dec_local;
            s_wdata_d        = sel_wdata;
          end else begin
            state_d          = ST_RESP;
            m_err_d[arb_idx] = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (slv_ack || cnt_q == TO_LAST) begin
          state_d   = ST_RESP;
          s_sel_d   = '0;
          s_we_d    = 1'b0;
          s_addr_d  = '0;
          s_wdata_d = '0;
          if (slv_ack) begin
            m_ack_d[win_q] = 1'b1;
            m_rdata_d      = s_we_q ? '0 : slv_rdata;
          end else begin
            m_err_d[win_q] = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        s_sel_d = '0;
      end
    endcase
  end

  // State and output registers; reset clears every bus output immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_q      <= MW'(NUM_MASTERS - 1);
      win_q     <= '0;
      slv_q     <= '0;
      cnt_q     <= '0;
      m_ack_q   <= '0;
      m_err_q   <= '0;
      m_rdata_q <= '0;
      s_sel_q   <= '0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      win_q     <= win_d;
      slv_q     <= slv_d;
      cnt_q     <= cnt_d;
      m_ack_q   <= m_ack_d;
      m_err_q   <= m_err_d;
      m_rdata_q <= m_rdata_d;
      s_sel_q   <= s_sel_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
    end
  end

  assign m_ack   = m_ack_q;
  assign m_err   = m_err_q;
  assign m_rdata = m_rdata_q;
  assign s_sel   = s_sel_q;
  assign s_we    = s_we_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;

endmodule

// File: tb/tb_skeleton_bus_arbiter.sv
// tb/tb_skeleton_bus_arbiter.sv - directed self-checking bench for skeleton_bus_arbiter
module tb_skeleton_bus_arbiter;
  localparam int NM = 4;
  localparam int NS = 2;
  localparam int AW = 16;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     m_req;
  logic [NM-1:0]     m_we;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_wdata;
  logic [NM-1:0]     m_ack;
  logic [NM-1:0]     m_err;
  logic [DW-1:0]     m_rdata;
  logic [NS-1:0]     s_sel;
  logic              s_we;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [NS-1:0]     s_ack;
  logic [NS*DW-1:0]  s_rdata;

  int pass_cnt = 0;
  int total    = 0;
  int ack_after = 0;
  bit wrong_slave = 1'b0;
  int acc_cnt = 0;

  always #5 clk = ~clk;

  skeleton_bus_arbiter #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
    .SLAVE_BASE({16'd35840, 16'd8192}), .SLAVE_SIZE({16'd1024, 16'd256}),
    .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata)
  );

  // Slave responder: acks in the ack_after-th cycle of an access (0 = never)
  always @(negedge clk) begin
    if (|s_sel) begin
      acc_cnt = acc_cnt + 1;
      if (ack_after != 0 && acc_cnt == ack_after) s_ack = wrong_slave ? ~s_sel : s_sel;
      else s_ack = '0;
    end else begin
      acc_cnt = 0;
      s_ack = '0;
    end
  end

  task automatic req(input int m, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_req[m] = 1'b1;
    m_we[m] = we;
    m_addr[m*AW +: AW] = a;
    m_wdata[m*DW +: DW] = d;
  endtask

  task automatic wait_done(input int start, output int cyc, output int sel_cyc,
                           output logic [NS-1:0] first_sel, output logic [AW-1:0] first_addr);
    cyc = start;
    sel_cyc = 0;
    first_sel = '0;
    first_addr = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      cyc++;
      if (|s_sel) sel_cyc++;
      if (cyc == 1) begin
        first_sel = s_sel;
        first_addr = s_addr;
      end
      if ((|m_ack) || (|m_err)) return;
    end
    cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    s_ack = '0;
    s_rdata = {16'hCAFE, 16'hBEEF};
    repeat (2) @(negedge clk);
    total++;
    if ({m_ack, m_err, m_rdata, s_sel, s_we, s_addr, s_wdata} !== '0)
      $display("FAIL reset_outputs: got %h want 0", {m_ack, m_err, m_rdata, s_sel, s_we, s_addr, s_wdata});
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int cyc, sc;
    logic [NS-1:0] fs;
    logic [AW-1:0] fa;
    ack_after = 1; wrong_slave = 1'b0;
    for (int i = 0; i < NM; i++) req(i, 1'b0, 16'(16'h2000 + i), '0);
    for (int g = 0; g < 8; g++) begin
      wait_done(0, cyc, sc, fs, fa);
      total++;
      if (m_ack !== 4'(1 << (g % 4)))
        $display("FAIL rr_grant%0d: got %b want %b", g, m_ack, 4'(1 << (g % 4)));
      else pass_cnt++;
      total++;
      if (m_rdata !== 16'hBEEF) $display("FAIL rr_rdata%0d: got %h want beef", g, m_rdata);
      else pass_cnt++;
    end
    m_req = '0;
    @(negedge clk);
  endtask

  task automatic test_read();
    int cyc, sc;
    logic [NS-1:0] fs;
    logic [AW-1:0] fa;
    ack_after = 3; wrong_slave = 1'b0;
    req(0, 1'b0, 16'h2005, '0);
    @(negedge clk);
    total++;
    if (s_sel !== 2'b01) $display("FAIL read_sel: got %b want 01", s_sel); else pass_cnt++;
    total++;
    if (s_addr !== 16'h0005) $display("FAIL read_addr: got %h want 0005", s_addr); else pass_cnt++;
    total++;
    if (s_we !== 1'b0) $display("FAIL read_we: got %b want 0", s_we); else pass_cnt++;
    m_req[0] = 1'b0;
    wait_done(1, cyc, sc, fs, fa);
    total++;
    if (cyc != 4) $display("FAIL read_latency: got %0d want 4", cyc); else pass_cnt++;
    total++;
    if ({m_ack, m_err} !== 8'b0001_0000) $display("FAIL read_ack: got %b want 00010000", {m_ack, m_err}); else pass_cnt++;
    total++;
    if (m_rdata !== 16'hBEEF) $display("FAIL read_rdata: got %h want beef", m_rdata); else pass_cnt++;
    @(negedge clk);
    total++;
    if ({m_ack, m_rdata} !== '0) $display("FAIL read_pulse: got %h want 0", {m_ack, m_rdata}); else pass_cnt++;
  endtask

  task automatic test_write();
    int cyc, sc;
    logic [NS-1:0] fs;
    logic [AW-1:0] fa;
    ack_after = 1; wrong_slave = 1'b0;
    req(2, 1'b1, 16'h8C10, 16'h1234);
    @(negedge clk);
    total++;
    if ({s_sel, s_we, s_addr, s_wdata} !== {2'b10, 1'b1, 16'h0010, 16'h1234})
      $display("FAIL write_bus: got %b/%b/%h/%h want 10/1/0010/1234", s_sel, s_we, s_addr, s_wdata);
    else pass_cnt++;
    wait_done(1, cyc, sc, fs, fa);
    total++;
    if (cyc != 2) $display("FAIL write_latency: got %0d want 2", cyc); else pass_cnt++;
    total++;
    if ({m_ack, m_err, m_rdata} !== {4'b0100, 4'b0000, 16'h0000})
      $display("FAIL write_ack: got %b/%b/%h want 0100/0000/0000", m_ack, m_err, m_rdata);
    else pass_cnt++;
    m_req = '0;
    @(negedge clk);
  endtask

  task automatic test_decode();
    int cyc, sc;
    logic [NS-1:0] fs;
    logic [AW-1:0] fa;
    logic [AW-1:0] addrs [5] = '{16'h0000, 16'h2100, 16'h1FFF, 16'h9000, 16'h20FF};
    logic [NS-1:0] sels  [5] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    ack_after = 1; wrong_slave = 1'b0;
    for (int t = 0; t < 5; t++) begin
      req(1, 1'b0, addrs[t], '0);
      wait_done(0, cyc, sc, fs, fa);
      total++;
      if (fs !== sels[t]) $display("FAIL decode_sel_%h: got %b want %b", addrs[t], fs, sels[t]); else pass_cnt++;
      if (sels[t] == 2'b00) begin
        total++;
        if (cyc != 1 || m_err !== 4'b0010 || m_ack !== 4'b0000)
          $display("FAIL decode_miss_%h: got cyc %0d err %b ack %b want 1/0010/0000", addrs[t], cyc, m_err, m_ack);
        else pass_cnt++;
      end else begin
        total++;
        if (cyc != 2 || m_ack !== 4'b0010 || fa !== 16'h00FF)
          $display("FAIL decode_hit_%h: got cyc %0d ack %b addr %h want 2/0010/00ff", addrs[t], cyc, m_ack, fa);
        else pass_cnt++;
      end
      m_req = '0;
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    int cyc, sc;
    logic [NS-1:0] fs;
    logic [AW-1:0] fa;
    int       after [3] = '{0, 8, 3};
    bit       wrong [3] = '{1'b0, 1'b0, 1'b1};
    logic [NM-1:0] eack [3] = '{4'b0000, 4'b1000, 4'b0000};
    logic [NM-1:0] eerr [3] = '{4'b1000, 4'b0000, 4'b1000};
    for (int t = 0; t < 3; t++) begin
      ack_after = after[t]; wrong_slave = wrong[t];
      req(3, 1'b0, 16'h8C00, '0);
      wait_done(0, cyc, sc, fs, fa);
      total++;
      if (sc != 8 || cyc != 9) $display("FAIL timeout_len%0d: got sel %0d cyc %0d want 8/9", t, sc, cyc); else pass_cnt++;
      total++;
      if (m_ack !== eack[t] || m_err !== eerr[t])
        $display("FAIL timeout_resp%0d: got ack %b err %b want %b/%b", t, m_ack, m_err, eack[t], eerr[t]);
      else pass_cnt++;
      m_req = '0;
      @(negedge clk);
    end
    wrong_slave = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc, sc;
    logic [NS-1:0] fs;
    logic [AW-1:0] fa;
    ack_after = 0; wrong_slave = 1'b0;
    req(2, 1'b1, 16'h2000, 16'h5A5A);
    repeat (2) @(negedge clk);
    total++;
    if (s_sel !== 2'b01) $display("FAIL rstmid_sel: got %b want 01", s_sel); else pass_cnt++;
    rst = 1'b1;
    #1;
    total++;
    if ({m_ack, m_err, m_rdata, s_sel, s_we, s_addr, s_wdata} !== '0)
      $display("FAIL rstmid_async: got %h want 0", {m_ack, m_err, m_rdata, s_sel, s_we, s_addr, s_wdata});
    else pass_cnt++;
    m_req = '0;
    @(negedge clk);
    total++;
    if ({m_ack, m_err} !== '0) $display("FAIL rstmid_noack: got %b want 0", {m_ack, m_err}); else pass_cnt++;
    rst = 1'b0;
    ack_after = 1;
    for (int i = 0; i < NM; i++) req(i, 1'b0, 16'h2000, '0);
    wait_done(0, cyc, sc, fs, fa);
    total++;
    if (cyc != 2 || m_ack !== 4'b0001) $display("FAIL rstmid_first: got cyc %0d ack %b want 2/0001", cyc, m_ack); else pass_cnt++;
    m_req = '0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_read();
    test_write();
    test_decode();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
